// File: rtl/phys_freelist.sv
// phys_freelist: rename-stage physical tag free list.
// Hands out up to two tags per cycle from a circular FIFO and takes back up to
// two retired tags per cycle at the tail. A speculative head serves allocation
// and a committed head tracks retirement, so a flush rolls back in one cycle.
// Optional macro FREELIST_CHK_EN adds a per-tag free-vector and a sticky
// chk_err output that flags double frees and allocation of non-free tags.
//
// Handshake: alloc_req is a per-slot request and alloc_gnt is an all-or-nothing
// combinational grant. Tags are consumed only in a cycle where alloc_gnt is 1;
// with alloc_gnt 0 nothing moves and the requester retries. free_en and
// commit_cnt are unconditional (there is no back-pressure on them).
module phys_freelist #(
  parameter int NPHYS = 32,
  parameter int NARCH = 16,
  parameter int PRW   = $clog2(NPHYS),
  parameter int DEPTH = NPHYS - NARCH,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          alloc_req,
  output logic                alloc_gnt,
  output logic [1:0][PRW-1:0] alloc_tag,
  input  logic [1:0]          free_en,
  input  logic [1:0][PRW-1:0] free_tag,
  input  logic [1:0]          commit_cnt,
  input  logic                recover,
  output logic [PW-1:0]       free_count,
  output logic                empty
`ifdef FREELIST_CHK_EN
  ,
  output logic                chk_err
`endif
);

  localparam int IW = PW - 1;

  logic [PRW-1:0] r_entry [DEPTH];
  logic [PW-1:0]  r_spec_head;
  logic [PW-1:0]  r_commit_head;
  logic [PW-1:0]  r_tail;

  logic [1:0]     w_alloc_n;
  logic [1:0]     w_free_n;
  logic [PW-1:0]  w_spec_head1;
  logic [PW-1:0]  w_tail1;
  logic [IW-1:0]  w_free_idx1;
  logic [PW-1:0]  w_commit_next;
  logic [PW-1:0]  w_tail_next;

  // Request/free counts and the "next slot" pointers used by the second lane.
  always_comb begin
    w_alloc_n     = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    w_free_n      = {1'b0, free_en[0]} + {1'b0, free_en[1]};
    w_spec_head1  = r_spec_head + PW'(1);
    w_tail1       = r_tail + PW'(1);
    w_free_idx1   = free_en[0] ? w_tail1[IW-1:0] : r_tail[IW-1:0];
    w_commit_next = r_commit_head + PW'(commit_cnt);
    w_tail_next   = r_tail + PW'(w_free_n);
  end

  // Occupancy, grant and zero-latency tag read from the speculative head.
  always_comb begin
    free_count   = r_tail - r_spec_head;
    empty        = (free_count == '0);
    alloc_gnt    = !rst && !recover && (free_count >= PW'(w_alloc_n));
    alloc_tag[0] = r_entry[r_spec_head[IW-1:0]];
    alloc_tag[1] = alloc_req[0] ? r_entry[w_spec_head1[IW-1:0]]
                                : r_entry[r_spec_head[IW-1:0]];
  end

  // Pointer updates: each pointer moves independently every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PW'(DEPTH);
    end else begin
      r_commit_head <= w_commit_next;
      r_tail        <= w_tail_next;
      if (recover) begin
        r_spec_head <= w_commit_next;
      end else if (alloc_gnt) begin
        r_spec_head <= r_spec_head + PW'(w_alloc_n);
      end
    end
  end

  // Tag storage: reset holds the unmapped tags, frees write at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= PRW'(NARCH + i);
      end
    end else begin
      if (free_en[0]) begin
        r_entry[r_tail[IW-1:0]] <= free_tag[0];
      end
      if (free_en[1]) begin
        r_entry[w_free_idx1] <= free_tag[1];
      end
    end
  end

`ifndef SYNTHESIS
  logic [PW-1:0] w_inflight;
  logic [PW-1:0] w_occ_next;
  assign w_inflight = r_spec_head - r_commit_head;
  assign w_occ_next = w_tail_next - w_commit_next;

  // Illegal usage by the surrounding pipeline; no hardware recovery exists.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (commit_cnt != 2'd3);
      assert (PW'(commit_cnt) <= w_inflight);
      assert (w_occ_next <= PW'(DEPTH));
    end
  end
`endif

`ifdef FREELIST_CHK_EN
  logic [NPHYS-1:0] r_free_vec;
  logic [NPHYS-1:0] w_free_vec_next;
  logic             w_chk_hit;
  logic             r_chk_err;

  // Shadow free-vector: granted allocs clear, frees set; flag inconsistencies.
  always_comb begin
    w_free_vec_next = r_free_vec;
    w_chk_hit       = 1'b0;
    if (alloc_gnt) begin
      if (alloc_req[0]) begin
        if (!r_free_vec[alloc_tag[0]]) w_chk_hit = 1'b1;
        w_free_vec_next[alloc_tag[0]] = 1'b0;
      end
      if (alloc_req[1]) begin
        if (!r_free_vec[alloc_tag[1]]) w_chk_hit = 1'b1;
        w_free_vec_next[alloc_tag[1]] = 1'b0;
      end
    end
    if (free_en[0]) begin
      if (r_free_vec[free_tag[0]]) w_chk_hit = 1'b1;
      w_free_vec_next[free_tag[0]] = 1'b1;
    end
    if (free_en[1]) begin
      if (r_free_vec[free_tag[1]]) w_chk_hit = 1'b1;
      w_free_vec_next[free_tag[1]] = 1'b1;
    end
    if (free_en == 2'b11 && free_tag[0] == free_tag[1]) w_chk_hit = 1'b1;
  end

  // Free-vector and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPHYS; i++) begin
        r_free_vec[i] <= (i >= NARCH);
      end
      r_chk_err <= 1'b0;
    end else begin
      r_free_vec <= w_free_vec_next;
      if (w_chk_hit) r_chk_err <= 1'b1;
    end
  end

  assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_phys_freelist.sv
// Testbench for phys_freelist. The reference model keeps three tag pools as
// queues: avail (allocatable, FIFO order), inflight (allocated, not yet
// committed, oldest first) and held (mapped in the architectural state).
module tb_phys_freelist;

  localparam int NPHYS = 32;
  localparam int NARCH = 16;
  localparam int PRW   = 5;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          alloc_req;
  logic                alloc_gnt;
  logic [1:0][PRW-1:0] alloc_tag;
  logic [1:0]          free_en;
  logic [1:0][PRW-1:0] free_tag;
  logic [1:0]          commit_cnt;
  logic                recover;
  logic [PW-1:0]       free_count;
  logic                empty;
`ifdef FREELIST_CHK_EN
  logic                chk_err;
`endif

  int total = 0;
  int bad   = 0;

  int avail[$];
  int inflight[$];
  int held[$];

  phys_freelist #(
    .NPHYS(NPHYS), .NARCH(NARCH), .PRW(PRW), .DEPTH(DEPTH), .PW(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_tag  (alloc_tag),
    .free_en    (free_en),
    .free_tag   (free_tag),
    .commit_cnt (commit_cnt),
    .recover    (recover),
    .free_count (free_count),
`ifdef FREELIST_CHK_EN
    .chk_err    (chk_err),
`endif
    .empty      (empty)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic int popc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic void model_reset();
    avail.delete();
    inflight.delete();
    held.delete();
    for (int i = 0; i < NARCH; i++) held.push_back(i);
    for (int i = NARCH; i < NPHYS; i++) avail.push_back(i);
  endfunction

  function automatic void remove_held(input int t);
    for (int i = 0; i < held.size(); i++) begin
      if (held[i] == t) begin
        held.delete(i);
        return;
      end
    end
  endfunction

  function automatic logic m_gnt();
    return !rst && !recover && (popc2(alloc_req) <= avail.size());
  endfunction

  function automatic int m_tag1();
    return alloc_req[0] ? avail[1] : avail[0];
  endfunction

  // Driver: apply inputs just after the falling edge and let them settle.
  task automatic drive(input logic [1:0] req, input logic [1:0] fe, input int t0,
                       input int t1, input logic [1:0] cc, input logic rc);
    alloc_req   = req;
    free_en     = fe;
    free_tag[0] = PRW'(t0);
    free_tag[1] = PRW'(t1);
    commit_cnt  = cc;
    recover     = rc;
    #1;
  endtask

  // Advance one clock and apply the same cycle's events to the model.
  task automatic tick();
    logic g;
    int   n;
    int   c;
    g = m_gnt();
    n = popc2(alloc_req);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g) for (int i = 0; i < n; i++) inflight.push_back(avail.pop_front());
      for (int i = 0; i < int'(commit_cnt); i++) begin
        c = inflight.pop_front();
        held.push_back(c);
      end
      if (recover) while (inflight.size() > 0) avail.push_front(inflight.pop_back());
      if (free_en[0]) begin avail.push_back(int'(free_tag[0])); remove_held(int'(free_tag[0])); end
      if (free_en[1]) begin avail.push_back(int'(free_tag[1])); remove_held(int'(free_tag[1])); end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_in_rst got=%0d exp=0", alloc_gnt); end
    tick();
    tick();
    rst = 1'b0;
    drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (free_count !== 5'd16) begin bad++; $display("FAIL reset_free_count got=%0d exp=16", free_count); end
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%0d exp=0", empty); end
    total++;
    if (alloc_gnt !== 1'b1) begin bad++; $display("FAIL reset_first_gnt got=%0d exp=1", alloc_gnt); end
    total++;
    if (alloc_tag[0] !== 5'd16 || alloc_tag[1] !== 5'd17) begin
      bad++; $display("FAIL reset_tags got=%0d,%0d exp=16,17", alloc_tag[0], alloc_tag[1]);
    end
`ifdef FREELIST_CHK_EN
    total++;
    if (chk_err !== 1'b0) begin bad++; $display("FAIL reset_chk_err got=%0d exp=0", chk_err); end
`endif
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (free_count !== 5'd14) begin bad++; $display("FAIL first_alloc_count got=%0d exp=14", free_count); end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 8; i++) begin
      drive(2'b11, 2'b00, 0, 0, 2'd2, 1'b0);
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag[0] !== PRW'(16 + 2*i) || alloc_tag[1] !== PRW'(17 + 2*i)) begin
        bad++; $display("FAIL fill_alloc%0d got=gnt%0d %0d,%0d exp=gnt1 %0d,%0d",
                        i, alloc_gnt, alloc_tag[0], alloc_tag[1], 16 + 2*i, 17 + 2*i);
      end
      tick();
    end
    drive(2'b01, 2'b00, 0, 0, 2'd2, 1'b0);
    total++;
    if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL empty_gnt got=%0d exp=0", alloc_gnt); end
    total++;
    if (empty !== 1'b1 || free_count !== 5'd0) begin
      bad++; $display("FAIL empty_flag got=%0d/%0d exp=1/0", empty, free_count);
    end
    tick();
    drive(2'b01, 2'b01, 5, 0, 2'd0, 1'b0);
    total++;
    if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL no_bypass_gnt got=%0d exp=0", alloc_gnt); end
    tick();
    drive(2'b01, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (alloc_gnt !== 1'b1 || alloc_tag[0] !== 5'd5) begin
      bad++; $display("FAIL freed_tag_alloc got=gnt%0d %0d exp=gnt1 5", alloc_gnt, alloc_tag[0]);
    end
    total++;
    if (free_count !== 5'd1) begin bad++; $display("FAIL freed_count got=%0d exp=1", free_count); end
    tick();
  endtask

  task automatic test_wrap();
    int tmp[$];
    int ft[16];
    int k;
    int cc;
    while (avail.size() > 0) begin
      cc = (inflight.size() >= 2) ? 2 : inflight.size();
      drive((avail.size() >= 2) ? 2'b11 : 2'b01, 2'b00, 0, 0, 2'(cc), 1'b0);
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag[0] !== PRW'(avail[0])) begin
        bad++; $display("FAIL drain_tag got=gnt%0d %0d exp=gnt1 %0d", alloc_gnt, alloc_tag[0], avail[0]);
      end
      tick();
    end
    while (inflight.size() > 0) begin
      cc = (inflight.size() >= 2) ? 2 : inflight.size();
      drive(2'b00, 2'b00, 0, 0, 2'(cc), 1'b0);
      tick();
    end
    tmp = held;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, tmp.size() - 1);
      ft[i] = tmp[k];
      tmp.delete(k);
    end
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 2'b11, ft[2*i], ft[2*i+1], 2'd0, 1'b0);
      tick();
    end
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (free_count !== 5'd16 || empty !== 1'b0) begin
      bad++; $display("FAIL wrap_full_count got=%0d exp=16", free_count);
    end
    for (int i = 0; i < 8; i++) begin
      cc = (inflight.size() >= 2) ? 2 : inflight.size();
      drive(2'b11, 2'b00, 0, 0, 2'(cc), 1'b0);
      total++;
      if (alloc_gnt !== 1'b1 || alloc_tag[0] !== PRW'(ft[2*i]) || alloc_tag[1] !== PRW'(ft[2*i+1])) begin
        bad++; $display("FAIL wrap_fifo%0d got=gnt%0d %0d,%0d exp=gnt1 %0d,%0d",
                        i, alloc_gnt, alloc_tag[0], alloc_tag[1], ft[2*i], ft[2*i+1]);
      end
      tick();
    end
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0d exp=1", empty); end
    while (inflight.size() > 0) begin
      cc = (inflight.size() >= 2) ? 2 : inflight.size();
      drive(2'b00, 2'b00, 0, 0, 2'(cc), 1'b0);
      tick();
    end
  endtask

  task automatic test_recover();
    do_reset();
    drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 0, 0, 2'd2, 1'b1);
    total++;
    if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL recover_gnt got=%0d exp=0", alloc_gnt); end
    tick();
    drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (free_count !== 5'd14) begin bad++; $display("FAIL recover_count got=%0d exp=14", free_count); end
    total++;
    if (alloc_gnt !== 1'b1 || alloc_tag[0] !== 5'd18 || alloc_tag[1] !== 5'd19) begin
      bad++; $display("FAIL recover_tags got=gnt%0d %0d,%0d exp=gnt1 18,19", alloc_gnt, alloc_tag[0], alloc_tag[1]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [1:0] fe;
    int maxc;
    int maxf;
    int i0;
    int i1;
    int t0;
    int t1;
    logic g;
    int e0;
    int e1;
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        rst = 1'b1;
        drive(2'b11, 2'b00, 0, 0, 2'd0, 1'b0);
        total++;
        if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL rand_rst_gnt got=%0d exp=0", alloc_gnt); end
        tick();
        rst = 1'b0;
      end
      req  = 2'($urandom_range(0, 3));
      maxc = (inflight.size() >= 2) ? 2 : inflight.size();
      maxf = held.size() - 16;
      if (maxf > 2) maxf = 2;
      fe = 2'b00;
      t0 = 0;
      t1 = 0;
      if (maxf >= 1) begin
        i0 = $urandom_range(0, held.size() - 1);
        t0 = held[i0];
        fe[0] = 1'($urandom_range(0, 1));
      end
      if (maxf >= 2) begin
        i1 = $urandom_range(0, held.size() - 1);
        if (i1 == i0) i1 = (i0 + 1) % held.size();
        t1 = held[i1];
        fe[1] = 1'($urandom_range(0, 1));
      end
      if (fe == 2'b10) begin fe = 2'b01; t0 = t1; end
      drive(req, fe, t0, t1, 2'($urandom_range(0, maxc)), ($urandom_range(0, 11) == 0));
      g = m_gnt();
      total++;
      if (alloc_gnt !== g) begin bad++; $display("FAIL rand_gnt it=%0d got=%0d exp=%0d", it, alloc_gnt, g); end
      total++;
      if (free_count !== PW'(avail.size()) || empty !== (avail.size() == 0)) begin
        bad++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, free_count, avail.size());
      end
      if (g && req[0]) begin
        e0 = avail[0];
        total++;
        if (alloc_tag[0] !== PRW'(e0)) begin bad++; $display("FAIL rand_tag0 it=%0d got=%0d exp=%0d", it, alloc_tag[0], e0); end
      end
      if (g && req[1]) begin
        e1 = m_tag1();
        total++;
        if (alloc_tag[1] !== PRW'(e1)) begin bad++; $display("FAIL rand_tag1 it=%0d got=%0d exp=%0d", it, alloc_tag[1], e1); end
      end
      tick();
    end
`ifdef FREELIST_CHK_EN
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (chk_err !== 1'b0) begin bad++; $display("FAIL rand_chk_err got=%0d exp=0", chk_err); end
`endif
  endtask

`ifdef FREELIST_CHK_EN
  task automatic test_chk();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b00, 0, 0, (i > 0) ? 2'd2 : 2'd0, 1'b0);
      tick();
    end
    drive(2'b00, 2'b00, 0, 0, 2'd2, 1'b0);
    tick();
    drive(2'b00, 2'b01, 20, 0, 2'd0, 1'b0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_legal_free got=%0d exp=0", chk_err); end
    drive(2'b00, 2'b01, 20, 0, 2'd0, 1'b0);
    tick();
    drive(2'b00, 2'b00, 0, 0, 2'd0, 1'b0);
    total++;
    if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_double_free got=%0d exp=1", chk_err); end
    tick();
    tick();
    total++;
    if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_sticky got=%0d exp=1", chk_err); end
    do_reset();
    total++;
    if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_cleared got=%0d exp=0", chk_err); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_wrap();
    test_recover();
    test_random();
`ifdef FREELIST_CHK_EN
    test_chk();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
